// File: rtl/x_delay_line_pkg.sv
// Shared state type and width helper for the delay-line TDC.
package x_delay_line_pkg;

   typedef enum logic [2:0] {
      StIdle,
      StLaunch,
      StSettle,
      StCapture,
      StResult
   } tdc_state_e;

   // Width able to hold a leading-ones count of 0..n_taps.
   function automatic int unsigned code_w(input int unsigned n_taps);
      return $clog2(n_taps + 1);
   endfunction

endpackage

// File: rtl/x_delay_line_tdc_if.sv
// Control and result handshake between the TDC and its readout consumer.
interface x_delay_line_tdc_if
   import x_delay_line_pkg::*;
#(
   parameter int unsigned N_TAPS   = 32,
   parameter int unsigned LOG2_AVG = 2
);
   localparam int unsigned CODE_W = code_w(N_TAPS);

   logic                       start;
   logic                       cont;
   logic                       ready;
   logic                       busy;
   logic                       valid;
   logic [N_TAPS-1:0]          raw;
   logic [CODE_W-1:0]          code;
   logic [CODE_W+LOG2_AVG-1:0] sum;
   logic                       err;

   modport master (
      output start, cont, ready,
      input  busy, valid, raw, code, sum, err
   );

   modport slave (
      input  start, cont, ready,
      output busy, valid, raw, code, sum, err
   );

endinterface

// File: rtl/x_delay_line_bulk.sv
// Bulk delay stage: a kept buffer placed ahead of the tap chain.
module x_delay_line_bulk (
   input  logic in_i,
   output logic out_o
);
   (* keep *) logic buf_w;

   assign buf_w = in_i;
   assign out_o = buf_w;

endmodule

// File: rtl/x_delay_line_cell.sv
// Tap cell: kept buffer in the chain plus a flop sampling the cell input.
module x_delay_line_cell (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic en_i,
   input  logic d_i,
   output logic d_o,
   output logic q_o
);
   (* keep *) logic buf_w;
   (* keep *) logic tap_q;

   assign buf_w = d_i;
   assign d_o   = buf_w;
   assign q_o   = tap_q;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         tap_q <= 1'b0;
      end else if (en_i) begin
         tap_q <= d_i;
      end
   end

endmodule

// File: rtl/x_delay_line_therm_enc.sv
// Thermometer encoder: leading-ones count from tap 0, plus a bubble flag.
module x_delay_line_therm_enc
   import x_delay_line_pkg::*;
#(
   parameter int unsigned N_TAPS = 32,
   localparam int unsigned CODE_W = code_w(N_TAPS)
) (
   input  logic [N_TAPS-1:0] taps_i,
   output logic [CODE_W-1:0] code_o,
   output logic              bubble_o
);
   logic seen_zero;

   always_comb begin
      code_o    = '0;
      bubble_o  = 1'b0;
      seen_zero = 1'b0;
      for (int unsigned i = 0; i < N_TAPS; i++) begin
         if (!taps_i[i]) begin
            seen_zero = 1'b1;
         end else if (seen_zero) begin
            bubble_o = 1'b1;
         end else begin
            code_o = CODE_W'(i + 1);
         end
      end
   end

endmodule

// File: rtl/x_delay_line_tdc.sv
// Delay-line TDC: launches an edge through bulk and tap cells, encodes the captured
// thermometer and averages 2^LOG2_AVG samples behind a valid/ready handshake.
module x_delay_line_tdc
   import x_delay_line_pkg::*;
#(
   parameter int unsigned N_BULK   = 17,
   parameter int unsigned N_TAPS   = 32,
   parameter int unsigned LOG2_AVG = 2
) (
   input logic               i_clk,
   input logic               i_rst_n,
   x_delay_line_tdc_if.slave tdc_if
);
   localparam int unsigned CODE_W  = code_w(N_TAPS);
   localparam int unsigned AccW    = CODE_W + LOG2_AVG;
   localparam int unsigned CntW    = LOG2_AVG + 1;
   localparam logic [CntW-1:0] CntLast = CntW'((1 << LOG2_AVG) - 1);

   tdc_state_e        state_q, state_d;
   logic              launch_q, launch_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [AccW-1:0]   acc_q, acc_d;
   logic [N_TAPS-1:0] raw_q, raw_d;
   logic              err_q, err_d;
   logic              cap_en;

   (* keep *) logic [N_BULK:0] bulk_w;
   (* keep *) logic [N_TAPS:0] chain_w;
   logic [N_TAPS-1:0] taps_q;
   logic [N_TAPS-1:0] taps_norm_w;
   logic [CODE_W-1:0] enc_code;
   logic              enc_bubble;
   logic              unused_tail_w;

   assign bulk_w[0] = launch_q;

   for (genvar b = 0; b < N_BULK; b++) begin : gen_bulk
      x_delay_line_bulk u_bulk (
         .in_i  (bulk_w[b]),
         .out_o (bulk_w[b+1])
      );
   end

   assign chain_w[0] = bulk_w[N_BULK];

   for (genvar t = 0; t < N_TAPS; t++) begin : gen_tap
      x_delay_line_cell u_cell (
         .clk_i  (i_clk),
         .rst_ni (i_rst_n),
         .en_i   (cap_en),
         .d_i    (chain_w[t]),
         .d_o    (chain_w[t+1]),
         .q_o    (taps_q[t])
      );
   end

   assign unused_tail_w = chain_w[N_TAPS];

   // Taps hold the launched level once the edge has passed; flip so that reads as 1.
   assign taps_norm_w = taps_q ^ {N_TAPS{~launch_q}};

   x_delay_line_therm_enc #(
      .N_TAPS (N_TAPS)
   ) u_enc (
      .taps_i   (taps_norm_w),
      .code_o   (enc_code),
      .bubble_o (enc_bubble)
   );

   always_comb begin
      state_d  = state_q;
      launch_d = launch_q;
      cnt_d    = cnt_q;
      acc_d    = acc_q;
      raw_d    = raw_q;
      err_d    = err_q;
      cap_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (tdc_if.start) begin
               state_d = StLaunch;
               cnt_d   = '0;
               acc_d   = '0;
               err_d   = 1'b0;
            end
         end
         StLaunch: begin
            launch_d = ~launch_q;
            state_d  = StSettle;
         end
         StSettle: begin
            cap_en  = 1'b1;
            state_d = StCapture;
         end
         StCapture: begin
            raw_d   = taps_norm_w;
            acc_d   = acc_q + AccW'(enc_code);
            err_d   = err_q | enc_bubble;
            cnt_d   = cnt_q + CntW'(1);
            state_d = (cnt_q == CntLast) ? StResult : StLaunch;
         end
         StResult: begin
            if (tdc_if.ready) begin
               if (tdc_if.cont) begin
                  state_d = StLaunch;
                  cnt_d   = '0;
                  acc_d   = '0;
                  err_d   = 1'b0;
               end else begin
                  state_d = StIdle;
               end
            end
         end
         default: state_d = StIdle;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q  <= StIdle;
         launch_q <= 1'b0;
         cnt_q    <= '0;
         acc_q    <= '0;
         raw_q    <= '0;
         err_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         launch_q <= launch_d;
         cnt_q    <= cnt_d;
         acc_q    <= acc_d;
         raw_q    <= raw_d;
         err_q    <= err_d;
      end
   end

   assign tdc_if.busy  = (state_q != StIdle);
   assign tdc_if.valid = (state_q == StResult);
   assign tdc_if.raw   = raw_q;
   assign tdc_if.sum   = acc_q;
   assign tdc_if.code  = CODE_W'(acc_q >> LOG2_AVG);
   assign tdc_if.err   = err_q;

endmodule

// File: tb/tb_x_delay_line_tdc.sv
// Directed bench for x_delay_line_tdc: one single-sample and one 4-sample instance,
// with the normalised tap vector forced to hand-chosen thermometer patterns.
module tb_x_delay_line_tdc;

   logic        clk   = 1'b0;
   logic        rst_n = 1'b1;
   logic [31:0] pat_a = '0;
   logic [31:0] pat_b = '0;
   int          n_checks = 0;
   int          n_fail   = 0;
   int          lat;
   logic [63:0] hold_sum;

   always #5 clk = ~clk;

   x_delay_line_tdc_if #(.N_TAPS(32), .LOG2_AVG(0)) if_a ();
   x_delay_line_tdc_if #(.N_TAPS(32), .LOG2_AVG(2)) if_b ();

   x_delay_line_tdc #(
      .N_BULK   (17),
      .N_TAPS   (32),
      .LOG2_AVG (0)
   ) dut_a (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .tdc_if  (if_a)
   );

   x_delay_line_tdc #(
      .N_BULK   (17),
      .N_TAPS   (32),
      .LOG2_AVG (2)
   ) dut_b (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .tdc_if  (if_b)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Start a 4-sample measurement on dut_b; each pattern is live for one capture edge.
   task automatic run_b(output int lat_o, input logic [31:0] p0, input logic [31:0] p1,
                        input logic [31:0] p2, input logic [31:0] p3);
      lat_o       = 0;
      pat_b       = p0;
      if_b.start  = 1'b1;
      for (int k = 1; k <= 40; k++) begin
         step();
         if_b.start = 1'b0;
         if (k == 4)  pat_b = p1;
         if (k == 7)  pat_b = p2;
         if (k == 10) pat_b = p3;
         if (if_b.valid) begin
            lat_o = k;
            break;
         end
      end
   endtask

   task automatic accept_b();
      if_b.ready = 1'b1;
      step();
      if_b.ready = 1'b0;
   endtask

   initial begin
      #50000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      if_a.start = 1'b0; if_a.cont = 1'b0; if_a.ready = 1'b0;
      if_b.start = 1'b0; if_b.cont = 1'b0; if_b.ready = 1'b0;
      force dut_a.taps_norm_w = pat_a;
      force dut_b.taps_norm_w = pat_b;

      #2 rst_n = 1'b0;
      #1;
      check_eq("rst_valid", 64'(if_b.valid), 0);
      check_eq("rst_busy",  64'(if_b.busy),  0);
      check_eq("rst_sum",   64'(if_b.sum),   0);
      check_eq("rst_raw",   64'(if_b.raw),   0);
      check_eq("rst_err",   64'(if_b.err),   0);
      check_eq("rst_valid_a", 64'(if_a.valid), 0);
      step();
      step();
      rst_n = 1'b1;

      // Single sample, 8 leading ones.
      lat        = 0;
      pat_a      = 32'h0000_00FF;
      if_a.start = 1'b1;
      for (int k = 1; k <= 20; k++) begin
         step();
         if_a.start = 1'b0;
         if (if_a.valid) begin
            lat = k;
            break;
         end
      end
      check_eq("a_latency", 64'(lat), 4);
      check_eq("a_code", 64'(if_a.code), 8);
      check_eq("a_sum",  64'(if_a.sum),  8);
      check_eq("a_err",  64'(if_a.err),  0);
      check_eq("a_raw",  64'(if_a.raw),  64'h0000_00FF);
      if_a.ready = 1'b1;
      step();
      if_a.ready = 1'b0;
      check_eq("a_valid_drop", 64'(if_a.valid), 0);
      check_eq("a_busy_idle",  64'(if_a.busy),  0);

      // Four samples with codes 5,6,6,7.
      run_b(lat, 32'h1F, 32'h3F, 32'h3F, 32'h7F);
      check_eq("b_latency", 64'(lat), 13);
      check_eq("b_sum",  64'(if_b.sum),  24);
      check_eq("b_code", 64'(if_b.code), 6);
      check_eq("b_err",  64'(if_b.err),  0);
      check_eq("b_raw",  64'(if_b.raw),  64'h7F);
      check_eq("b_launch", 64'(dut_b.launch_q), 0);
      accept_b();
      check_eq("b_valid_drop", 64'(if_b.valid), 0);

      // Bubble pattern.
      run_b(lat, 32'h0F0F, 32'h0F0F, 32'h0F0F, 32'h0F0F);
      check_eq("bub_code", 64'(if_b.code), 4);
      check_eq("bub_sum",  64'(if_b.sum),  16);
      check_eq("bub_err",  64'(if_b.err),  1);
      check_eq("bub_raw",  64'(if_b.raw),  64'h0F0F);
      accept_b();

      // Unforced zero-delay chain: edge passes every tap.
      release dut_b.taps_norm_w;
      run_b(lat, '0, '0, '0, '0);
      check_eq("ones_code", 64'(if_b.code), 32);
      check_eq("ones_sum",  64'(if_b.sum),  128);
      check_eq("ones_err",  64'(if_b.err),  0);
      check_eq("ones_raw",  64'(if_b.raw),  64'hFFFF_FFFF);
      accept_b();
      force dut_b.taps_norm_w = pat_b;

      run_b(lat, '0, '0, '0, '0);
      check_eq("zero_code", 64'(if_b.code), 0);
      check_eq("zero_err",  64'(if_b.err),  0);
      accept_b();

      // Backpressure: outputs hold, i_start ignored in RESULT.
      run_b(lat, 32'h1F, 32'h1F, 32'h1F, 32'h1F);
      hold_sum = 64'(if_b.sum);
      check_eq("hold_sum0", hold_sum, 20);
      pat_b = 32'h3;
      for (int c = 0; c < 10; c++) begin
         if_b.start = (c == 3);
         step();
         check_eq("hold_valid", 64'(if_b.valid), 1);
         check_eq("hold_sum",   64'(if_b.sum),   20);
         check_eq("hold_code",  64'(if_b.code),  5);
         check_eq("hold_raw",   64'(if_b.raw),   64'h1F);
      end
      if_b.start = 1'b0;
      accept_b();
      check_eq("hold_busy_after", 64'(if_b.busy), 0);
      step();
      check_eq("hold_busy_later", 64'(if_b.busy), 0);

      // Free-run: cleared accumulator and 12-cycle period.
      if_b.cont = 1'b1;
      run_b(lat, 32'h7, 32'h7, 32'h7, 32'h7);
      check_eq("fr_lat0", 64'(lat), 13);
      check_eq("fr_sum0", 64'(if_b.sum), 12);
      pat_b = 32'hF;
      accept_b();
      check_eq("fr_valid_drop", 64'(if_b.valid), 0);
      check_eq("fr_busy", 64'(if_b.busy), 1);
      lat = 0;
      for (int k = 1; k <= 40; k++) begin
         step();
         if (if_b.valid) begin
            lat = k;
            break;
         end
      end
      check_eq("fr_period", 64'(lat), 12);
      check_eq("fr_sum1",  64'(if_b.sum),  16);
      check_eq("fr_code1", 64'(if_b.code), 4);
      if_b.cont = 1'b0;
      accept_b();
      check_eq("fr_stop_busy",  64'(if_b.busy),  0);
      check_eq("fr_stop_valid", 64'(if_b.valid), 0);

      // Reset during SETTLE of the second sample.
      pat_b      = 32'h3F;
      if_b.start = 1'b1;
      for (int k = 1; k <= 5; k++) begin
         step();
         if_b.start = 1'b0;
      end
      check_eq("pre_rst_sum", 64'(if_b.sum), 6);
      rst_n = 1'b0;
      #1;
      check_eq("mid_rst_busy",   64'(if_b.busy),  0);
      check_eq("mid_rst_valid",  64'(if_b.valid), 0);
      check_eq("mid_rst_sum",    64'(if_b.sum),   0);
      check_eq("mid_rst_raw",    64'(if_b.raw),   0);
      check_eq("mid_rst_code",   64'(if_b.code),  0);
      check_eq("mid_rst_launch", 64'(dut_b.launch_q), 0);
      step();
      rst_n = 1'b1;
      run_b(lat, 32'h3F, 32'h3F, 32'h3F, 32'h3F);
      check_eq("post_rst_lat",  64'(lat), 13);
      check_eq("post_rst_sum",  64'(if_b.sum), 24);
      check_eq("post_rst_code", 64'(if_b.code), 6);
      accept_b();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
